// File: rtl/s2p_pkg.sv
// Shared types and defaults for the s2p_framer serial-to-parallel framer.
package s2p_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_SYNC  = 8'hA5;

    // Wide enough to hold the value WIDTH itself (fill counter saturates there).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/s2p_framer_if.sv
// Output word buffer handshake of s2p_framer: the framer is master, the consumer is slave.
interface s2p_framer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] o_data;
    logic             o_vld;
    logic             o_rdy;

    modport master (
        output o_data,
        output o_vld,
        input  o_rdy
    );

    modport slave (
        input  o_data,
        input  o_vld,
        output o_rdy
    );

endinterface

// File: rtl/s2p_shreg.sv
// WIDTH-bit left-shifting register with enable; new bits enter at the LSB.
module s2p_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= {q_reg[WIDTH-2:0], d};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/s2p_framer.sv
// Sync-word hunting serial-to-parallel framer with a one-entry valid/ready output buffer.
// Optional word counter output wcnt is enabled by defining S2P_WORD_CNT_EN.
module s2p_framer
    import s2p_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DEF_SYNC)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d,
    input  logic        d_en,
    input  logic        relock,
    s2p_framer_if.master out,
    output logic        locked,
    output logic        ovf
`ifdef S2P_WORD_CNT_EN
    ,
    output logic [15:0] wcnt
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [CW-1:0]    fill_reg;
    logic [CW-1:0]    fill_next;
    logic [CW-1:0]    bit_cnt_reg;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] data_reg;
    logic             vld_reg;
    logic             ovf_reg;
    logic             word_done;
    logic             drain;
    logic             sr_msb_unused;

    s2p_shreg #(
        .WIDTH (WIDTH)
    ) u_sr (
        .clk  (clk),
        .srst (rst),
        .clr  (relock),
        .en   (d_en),
        .d    (d),
        .q    (sr_q)
    );

    // The MSB falls off the end of every shift and never reaches a word.
    assign sr_msb_unused = sr_q[WIDTH-1];

    always_comb begin
        sr_next   = {sr_q[WIDTH-2:0], d};
        fill_next = (fill_reg == FULL) ? FULL : fill_reg + CW'(1);
        word_done = (state_reg == LOCK) && d_en && !relock && (bit_cnt_reg == LAST);
        drain     = vld_reg && out.o_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= HUNT;
            fill_reg    <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            vld_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            if (relock) begin
                state_reg   <= HUNT;
                fill_reg    <= '0;
                bit_cnt_reg <= '0;
            end else if (d_en) begin
                case (state_reg)
                    HUNT: begin
                        fill_reg <= fill_next;
                        // Requiring a full window stops a zero SYNC matching the cleared sr.
                        if ((fill_next == FULL) && (sr_next == SYNC)) begin
                            state_reg   <= LOCK;
                            bit_cnt_reg <= '0;
                        end
                    end
                    LOCK: begin
                        bit_cnt_reg <= (bit_cnt_reg == LAST) ? '0 : bit_cnt_reg + CW'(1);
                    end
                    default: state_reg <= HUNT;
                endcase
            end

            if (word_done) begin
                if (!vld_reg || out.o_rdy) begin
                    data_reg <= sr_next;
                    vld_reg  <= 1'b1;
                end else begin
                    ovf_reg  <= 1'b1;
                end
            end else if (drain) begin
                vld_reg <= 1'b0;
            end
        end
    end

`ifdef S2P_WORD_CNT_EN
    logic [15:0] wcnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_reg <= '0;
        end else if (word_done && (!vld_reg || out.o_rdy)) begin
            wcnt_reg <= wcnt_reg + 16'd1;
        end
    end

    assign wcnt = wcnt_reg;
`endif

    assign out.o_data = data_reg;
    assign out.o_vld  = vld_reg;
    assign locked     = (state_reg == LOCK);
    assign ovf        = ovf_reg;

endmodule

// File: doc/s2p_framer.md
# s2p_framer

Serial-to-parallel framer that consumes the 1-bit stream produced by the d-flop stage (its `q` output drives this block's `d`). It hunts for a WIDTH-bit sync word and then assembles subsequent bits into WIDTH-bit words. Each word is presented to the downstream consumer through a one-entry valid/ready output buffer.

## Interface
- WIDTH, 8, bits per word and per sync pattern (≥2)
- SYNC, 8'hA5, sync pattern (WIDTH bits), first bit on the wire is MSB
- clk  in  1  clock, rising-edge
- rst  in  1  reset; synchronous, active-high
- d  in  1  serial bit from the flop stage
- d_en  in  1  d is sampled only when d_en=1
- relock  in  1  one-cycle pulse: drop lock, return to hunting
- o_data  out  WIDTH  assembled word, MSB = first received bit
- o_vld  out  1  o_data holds an unconsumed word
- o_rdy  in  1  consumer accepts the word when o_vld&&o_rdy
- locked  out  1  sync found, words being assembled
- ovf  out  1  sticky: a completed word was dropped because the buffer was full

## Operation
- Shift register: on each d_en cycle, sr <= {sr[WIDTH-2:0], d}.
- FSM states:
  - HUNT (reset state): a fill counter counts d_en bits, saturating at WIDTH. Transition to LOCK in the cycle where fill==WIDTH after the shift and the shifted value == SYNC. The fill condition prevents a false match on the reset value when SYNC==0.
  - LOCK: a bit counter runs 0..WIDTH-1 on d_en. On the WIDTH-th bit the word {sr[WIDTH-2:0], d} completes and the bit counter wraps to 0. LOCK persists until relock or rst; the sync pattern is not re-checked.
- Buffer on word completion:
  - If o_vld=0, or o_vld&&o_rdy in the same cycle: load o_data, set o_vld=1.
  - Otherwise: drop the new word, set ovf=1, leave o_data unchanged.
- o_vld clears on o_vld&&o_rdy when no new word completes in that cycle.
- relock: go to HUNT, clear fill counter, bit counter and sr. The partial word is discarded. The buffer and ovf are kept.
- relock in the same cycle as word completion: relock wins and the word is discarded.
- ovf clears only on rst.
- d_en=0: no state change apart from the buffer drain.

## Timing
- Reset values: o_data=0, o_vld=0, locked=0, ovf=0, sr=0, FSM=HUNT.
- locked rises in the cycle after the final SYNC bit is sampled.
- The first data bit is the next d_en bit after that final SYNC bit.
- o_vld rises in the cycle after the WIDTH-th data bit is sampled (1-cycle latency). With continuous d_en, a new word arrives every WIDTH cycles.
- o_data stays stable while o_vld=1 and o_rdy=0.
- rst mid-word or mid-handshake: all state returns to reset values on the next edge, and any pending word is lost.

## Configuration
- S2P_WORD_CNT_EN defined:
  - Adds output port `wcnt` (16 bits).
  - Increments on every word loaded into the buffer. Dropped words are not counted.
  - Wraps 16'hFFFF→0, cleared by rst. relock does not clear it.
- Not defined: no `wcnt` port and no counter logic. All other behaviour is identical.

## Structure
- Package `s2p_pkg` holds:
  - the state enum (HUNT, LOCK)
  - default WIDTH/SYNC localparams
  - the counter width function clog2(WIDTH+1)
- One sub-module, `s2p_shreg`: parameterised WIDTH-bit shift register with enable and synchronous clear. It is used for sr.
- The FSM, counters and output buffer live in the top module.

## Test plan
- Sync and first word: WIDTH=8, SYNC=A5, d_en=1, o_rdy=1. Stream A5 then 3C. Required: locked=1 one cycle after the last A5 bit; o_vld=1 with o_data=8'h3C one cycle after the 8th data bit, for one cycle.
- Backpressure/overflow: after lock, send 11, 22 with o_rdy=0. Required: o_data stays 8'h11, ovf=1 after 22 completes. Then raise o_rdy: 11 is accepted, and o_vld falls next cycle.
- Drain-and-load same cycle: o_rdy pulses exactly in the cycle word 22 completes while 11 is pending. Required: 11 is accepted, o_data=8'h22, o_vld stays 1, ovf stays 0.
- d_en gaps / false sync: send bits with d_en toggling every other cycle; also a stream containing 0xA4 then 0xA5 offset by 3 bits. Required: lock only on an exact A5 alignment, and bits with d_en=0 are ignored.
- relock mid-word: after lock, send 4 data bits then pulse relock. Required: locked=0 next cycle, the partial word never appears, and a pending buffer word remains with o_vld=1.
- SYNC=8'h00 with rst release and d=0: locked rises only after 8 zero bits have been sampled, never earlier. With S2P_WORD_CNT_EN, wcnt counts delivered words only, excluding dropped ones.
